// File: rtl/nand3_pattern_sequencer_if.sv
// Stimulus/response bundle between the NAND3 pattern sequencer and its gate.
// The master side is the sequencer; the slave side is the gate and the observer.
interface nand3_pattern_sequencer_if;
  logic       start;
  logic       pause;
  logic       d_in;
  logic       e_in;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [3:0] err_cnt;
  logic [7:0] resp_d;
  logic [7:0] resp_e;
  logic       pass;

  modport master (
    input  start, pause, d_in, e_in,
    output a, b, c, busy, done,
    output err_cnt, resp_d, resp_e, pass
  );

  modport slave (
    output start, pause, d_in, e_in,
    input  a, b, c, busy, done,
    input  err_cnt, resp_d, resp_e, pass
  );
endinterface

// File: rtl/nand3_pattern_sequencer.sv
// Drives the 8 NAND3 input patterns, samples d/e once per pattern
// and counts mismatches against ~(a&b&c).
module nand3_pattern_sequencer #(
  parameter int DWELL = 20,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  nand3_pattern_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nx;
  logic [2:0]       idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       err, err_nx;
  logic [7:0]       rd, rd_nx;
  logic [7:0]       re, re_nx;

  logic       expect_d;
  logic [1:0] miss;
  logic [4:0] err_sum;

  assign expect_d = ~(&idx);
  assign miss     = 2'(bus.d_in != expect_d)
                  + 2'(bus.e_in != expect_d);
  assign err_sum  = 5'(err) + 5'(miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= '0;
      rd    <= '0;
      re    <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
      rd    <= rd_nx;
      re    <= re_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    err_nx   = err;
    rd_nx    = rd;
    re_nx    = re;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx = RUN;
          idx_nx   = '0;
          cnt_nx   = '0;
          err_nx   = '0;
          rd_nx    = '0;
          re_nx    = '0;
        end
      end
      RUN: begin
        if (!bus.pause) begin
          if (cnt != LAST) begin
            cnt_nx = cnt + 1'b1;
          end else begin
            // sample cycle: latch responses and score them
            rd_nx[idx] = bus.d_in;
            re_nx[idx] = bus.e_in;
            err_nx     = err_sum[4] ? 4'hF : err_sum[3:0];
            cnt_nx     = '0;
            if (idx != 3'd7) idx_nx = idx + 3'd1;
            else             state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign {bus.a, bus.b, bus.c} = idx;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.err_cnt = err;
  assign bus.resp_d  = rd;
  assign bus.resp_e  = re;
  assign bus.pass    = (state == DONE) && (err == 4'd0);

endmodule

// File: tb/tb_nand3_pattern_sequencer.sv
// Directed bench for the NAND3 pattern sequencer with a behavioural
// gate model whose fault mode is selected per scenario.
module tb_nand3_pattern_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   mode = 0;
  logic [2:0] snap [0:511];

  nand3_pattern_sequencer_if bus ();

  nand3_pattern_sequencer #(.DWELL(20), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // gate model: 0 good, 1 e stuck at 0, 2 both behave as AND
  always_comb begin
    bus.d_in = ~(bus.a & bus.b & bus.c);
    bus.e_in = ~(bus.a & bus.b & bus.c);
    if (mode == 1) bus.e_in = 1'b0;
    if (mode == 2) begin
      bus.d_in = bus.a & bus.b & bus.c;
      bus.e_in = bus.a & bus.b & bus.c;
    end
  end

  task automatic run(input int p_on, input int p_off,
                     input int re_at, output int lat);
    int n;
    lat = -1;
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    snap[0] = {bus.a, bus.b, bus.c};
    while (n < 400) begin
      @(negedge clk);
      bus.start = (n == re_at);
      bus.pause = (n >= p_on) && (n < p_off);
      @(posedge clk);
      #1;
      n++;
      snap[n] = {bus.a, bus.b, bus.c};
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.a, bus.b, bus.c, bus.busy, bus.done, bus.pass} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=000000",
               {bus.a, bus.b, bus.c, bus.busy, bus.done, bus.pass});
    end
    checks++;
    if ({bus.err_cnt, bus.resp_d, bus.resp_e} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=00000",
               {bus.err_cnt, bus.resp_d, bus.resp_e});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_gate();
    int lat;
    mode = 0;
    run(1000, 1000, -1, lat);
    checks++;
    if (lat !== 160) begin
      failures++;
      $display("FAIL good_latency got=%0d want=160", lat);
    end
    checks++;
    if (snap[0] !== 3'b000 || snap[19] !== 3'b000 || snap[20] !== 3'b001) begin
      failures++;
      $display("FAIL good_step got=%b,%b,%b want=000,000,001",
               snap[0], snap[19], snap[20]);
    end
    checks++;
    if (snap[159] !== 3'b111 || snap[160] !== 3'b111) begin
      failures++;
      $display("FAIL good_last got=%b,%b want=111,111", snap[159], snap[160]);
    end
    checks++;
    if (bus.resp_d !== 8'h7F || bus.resp_e !== 8'h7F || bus.err_cnt !== 4'd0) begin
      failures++;
      $display("FAIL good_resp got=%h/%h/%0d want=7f/7f/0",
               bus.resp_d, bus.resp_e, bus.err_cnt);
    end
    checks++;
    if (bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL good_pass got=%b%b want=10", bus.pass, bus.busy);
    end
  endtask

  task automatic test_e_stuck();
    int lat;
    mode = 1;
    run(1000, 1000, -1, lat);
    checks++;
    if (lat !== 160 || bus.resp_d !== 8'h7F || bus.resp_e !== 8'h00) begin
      failures++;
      $display("FAIL stuck_resp got=%0d/%h/%h want=160/7f/00",
               lat, bus.resp_d, bus.resp_e);
    end
    checks++;
    if (bus.err_cnt !== 4'd7 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck_err got=%0d/%b want=7/0", bus.err_cnt, bus.pass);
    end
    mode = 0;
  endtask

  task automatic test_pause();
    int lat;
    mode = 0;
    run(70, 85, -1, lat);
    checks++;
    if (lat !== 175) begin
      failures++;
      $display("FAIL pause_latency got=%0d want=175", lat);
    end
    checks++;
    if (snap[60] !== 3'b011 || snap[94] !== 3'b011 || snap[95] !== 3'b100) begin
      failures++;
      $display("FAIL pause_hold got=%b,%b,%b want=011,011,100",
               snap[60], snap[94], snap[95]);
    end
    checks++;
    if (bus.resp_d !== 8'h7F || bus.resp_e !== 8'h7F || bus.pass !== 1'b1) begin
      failures++;
      $display("FAIL pause_resp got=%h/%h/%b want=7f/7f/1",
               bus.resp_d, bus.resp_e, bus.pass);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    mode = 2;
    run(1000, 1000, -1, lat);
    checks++;
    if (bus.err_cnt !== 4'd15 || bus.pass !== 1'b0 || bus.resp_d !== 8'h80) begin
      failures++;
      $display("FAIL sat_err got=%0d/%b/%h want=15/0/80",
               bus.err_cnt, bus.pass, bus.resp_d);
    end
    mode = 0;
    run(1000, 1000, 49, lat);
    checks++;
    if (lat !== 160) begin
      failures++;
      $display("FAIL restart_ignored got=%0d want=160", lat);
    end
    checks++;
    if (bus.err_cnt !== 4'd0 || bus.pass !== 1'b1 || bus.resp_e !== 8'h7F) begin
      failures++;
      $display("FAIL restart_clear got=%0d/%b/%h want=0/1/7f",
               bus.err_cnt, bus.pass, bus.resp_e);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (n < 105) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({bus.a, bus.b, bus.c} !== 3'b101 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pattern got=%b%b want=1011",
               {bus.a, bus.b, bus.c}, bus.busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.a, bus.b, bus.c, bus.busy, bus.done} !== 5'b0 ||
        {bus.err_cnt, bus.resp_d, bus.resp_e} !== 20'h0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%h want=00000/00000",
               {bus.a, bus.b, bus.c, bus.busy, bus.done},
               {bus.err_cnt, bus.resp_d, bus.resp_e});
    end
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    run(1000, 1000, -1, lat);
    checks++;
    if (lat !== 160 || bus.resp_d !== 8'h7F || bus.pass !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_run got=%0d/%h/%b want=160/7f/1",
               lat, bus.resp_d, bus.pass);
    end
  endtask

  task automatic test_start_pause_idle();
    int lat;
    do_reset();
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.pause = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || {bus.a, bus.b, bus.c} !== 3'b000) begin
      failures++;
      $display("FAIL start_pause got=%b%b want=1000",
               bus.busy, {bus.a, bus.b, bus.c});
    end
    repeat (30) @(negedge clk);
    checks++;
    if ({bus.a, bus.b, bus.c} !== 3'b000 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL pause_held got=%b%b want=0000",
               {bus.a, bus.b, bus.c}, bus.done);
    end
    bus.pause = 1'b0;
    lat = 0;
    while (!bus.done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 160) begin
      failures++;
      $display("FAIL unpause_latency got=%0d want=160", lat);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    rst = 1'b1;
    test_reset();
    test_good_gate();
    test_e_stuck();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    test_start_pause_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
